// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART command frame parser driving a request/ack register bus
// Optional trailing XOR checksum byte enabled by defining UART_CMD_BRIDGE_CHKSUM_EN.
module uart_cmd_bridge #(
  parameter int         BUS_TIMEOUT = 255,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_deq_rxq,
  input  logic [7:0] i_rxq_data,
  input  logic       i_rxq_empty,
  output logic       o_enq_txq,
  output logic [7:0] o_txq_data,
  input  logic       i_txq_full,
  output logic       o_reg_req,
  output logic       o_reg_we,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic [7:0] i_reg_rdata,
  input  logic       i_reg_ack,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam int            CW       = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);
  localparam logic [7:0]    CMD_WR   = 8'h01;
  localparam logic [7:0]    CMD_RD   = 8'h02;
  localparam logic [7:0]    RSP_ACK  = 8'h06;
  localparam logic [7:0]    RSP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    IDLE, GET_CMD, GET_ADDR, GET_DATA,
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
    GET_CHK,
`endif
    BUS_WAIT, SEND_ACK, SEND_DATA, SEND_NAK
  } state_t;

  state_t        state;
  logic [7:0]    rdata;
  logic [CW-1:0] cnt;
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
  logic [7:0]    chk;
`endif

  logic rx_state, tx_state, take, send;

  always_comb begin
    rx_state = state inside {IDLE, GET_CMD, GET_ADDR, GET_DATA};
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
    if (state == GET_CHK) rx_state = 1'b1;
`endif
  end

  assign tx_state = state inside {SEND_ACK, SEND_DATA, SEND_NAK};
  // Reset gating keeps the strobes quiet while the bridge is held in reset.
  assign take     = i_rst_n && rx_state && !i_rxq_empty;
  assign send     = i_rst_n && tx_state && !i_txq_full;

  assign o_deq_rxq   = take;
  assign o_enq_txq   = send;
  assign o_frame_err = send && (state == SEND_NAK);
  assign o_busy      = (state != IDLE);

  always_comb begin
    o_txq_data = 8'h00;
    case (state)
      SEND_ACK:  o_txq_data = RSP_ACK;
      SEND_DATA: o_txq_data = rdata;
      SEND_NAK:  o_txq_data = RSP_NAK;
      default:   o_txq_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_reg_req   <= 1'b0;
      o_reg_we    <= 1'b0;
      o_reg_addr  <= 8'h00;
      o_reg_wdata <= 8'h00;
      rdata       <= 8'h00;
      cnt         <= '0;
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
      chk         <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take && i_rxq_data == SYNC_BYTE) state <= GET_CMD;
        end
        GET_CMD: begin
          if (take) begin
            if (i_rxq_data == CMD_WR || i_rxq_data == CMD_RD) begin
              o_reg_we    <= (i_rxq_data == CMD_WR);
              o_reg_wdata <= 8'h00;
              state       <= GET_ADDR;
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
              chk         <= i_rxq_data;
`endif
            end else begin
              state <= SEND_NAK;
            end
          end
        end
        GET_ADDR: begin
          if (take) begin
            o_reg_addr <= i_rxq_data;
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
            chk        <= chk ^ i_rxq_data;
`endif
            if (o_reg_we) begin
              state <= GET_DATA;
            end else begin
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
              state <= GET_CHK;
`else
              state     <= BUS_WAIT;
              o_reg_req <= 1'b1;
`endif
            end
          end
        end
        GET_DATA: begin
          if (take) begin
            o_reg_wdata <= i_rxq_data;
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
            chk         <= chk ^ i_rxq_data;
            state       <= GET_CHK;
`else
            state       <= BUS_WAIT;
            o_reg_req   <= 1'b1;
`endif
          end
        end
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
        GET_CHK: begin
          if (take) begin
            if (i_rxq_data == chk) begin
              state     <= BUS_WAIT;
              o_reg_req <= 1'b1;
            end else begin
              state <= SEND_NAK;
            end
          end
        end
`endif
        // Ack wins over timeout, so an ack on the final allowed cycle succeeds.
        BUS_WAIT: begin
          if (i_reg_ack) begin
            o_reg_req <= 1'b0;
            cnt       <= '0;
            if (!o_reg_we) rdata <= i_reg_rdata;
            state     <= SEND_ACK;
          end else if (cnt == CNT_LAST) begin
            o_reg_req <= 1'b0;
            cnt       <= '0;
            state     <= SEND_NAK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SEND_ACK: begin
          if (send) state <= o_reg_we ? IDLE : SEND_DATA;
        end
        SEND_DATA: begin
          if (send) state <= IDLE;
        end
        SEND_NAK: begin
          if (send) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - randomized self-checking bench for uart_cmd_bridge
`timescale 1ns/1ps
module tb_uart_cmd_bridge;

  localparam int         TMO     = 255;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_CYC = 3000;
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
  localparam int         LAT_W   = 5;
`else
  localparam int         LAT_W   = 4;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       o_deq_rxq;
  logic [7:0] i_rxq_data;
  logic       i_rxq_empty;
  logic       o_enq_txq;
  logic [7:0] o_txq_data;
  logic       i_txq_full;
  logic       o_reg_req;
  logic       o_reg_we;
  logic [7:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic [7:0] i_reg_rdata;
  logic       i_reg_ack;
  logic       o_busy;
  logic       o_frame_err;

  always #5 i_clk = ~i_clk;

  uart_cmd_bridge #(.BUS_TIMEOUT(TMO), .SYNC_BYTE(SYNC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_deq_rxq(o_deq_rxq), .i_rxq_data(i_rxq_data), .i_rxq_empty(i_rxq_empty),
    .o_enq_txq(o_enq_txq), .o_txq_data(o_txq_data), .i_txq_full(i_txq_full),
    .o_reg_req(o_reg_req), .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata), .i_reg_ack(i_reg_ack),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] frm[$];
  logic [7:0] src_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  logic [7:0] exp_tx[$];

  int gap_pct = 0, full_pct = 0, full_hold = 0, bp_arm = 0;
  int ack_delay = -1;
  logic [7:0] bus_rdata = 8'h00;
  bit pend_pop = 0;
  int cyc = 0;
  int req_run = 0, req_cnt, last_req_len, unstable, bad_enq, bad_deq, ferr_cnt;
  int sync_deq_cyc, req_rise_cyc, ack_cyc, first_enq_cyc;
  logic       seen_we;
  logic [7:0] seen_addr, seen_wdata;

  bit         exp_req;
  logic       exp_we;
  logic [7:0] exp_addr, exp_wdata;
  int         exp_len, exp_ferr;

  task automatic clear_stats();
    tx_got.delete();
    req_cnt = 0; last_req_len = 0; unstable = 0; bad_enq = 0; bad_deq = 0; ferr_cnt = 0;
    sync_deq_cyc = -1; req_rise_cyc = -1; ack_cyc = -1; first_enq_cyc = -1;
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic step();
    @(posedge i_clk); #1;
    if (pend_pop && rx_q.size() > 0) rx_q.delete(0);
    pend_pop = 0;
    if (src_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) rx_q.push_back(src_q.pop_front());
    i_rxq_empty = (rx_q.size() == 0);
    i_rxq_data  = i_rxq_empty ? 8'h00 : rx_q[0];
    if (full_hold > 0) begin
      i_txq_full = 1'b1;
      full_hold--;
    end else begin
      i_txq_full = (int'($urandom_range(0, 99)) < full_pct);
    end
    i_reg_ack = 1'b0;
    if (o_reg_req) begin
      if (req_run == 0) begin
        req_cnt++;
        seen_we = o_reg_we; seen_addr = o_reg_addr; seen_wdata = o_reg_wdata;
      end else if (o_reg_we !== seen_we || o_reg_addr !== seen_addr || o_reg_wdata !== seen_wdata) begin
        unstable++;
      end
      i_reg_ack   = (req_run == ack_delay);
      i_reg_rdata = i_reg_ack ? bus_rdata : 8'($urandom);
      req_run++;
      last_req_len = req_run;
      if (i_reg_ack) begin
        ack_cyc = cyc;
        if (bp_arm > 0) begin
          full_hold = bp_arm;
          bp_arm = 0;
        end
      end
    end else begin
      req_run = 0;
    end
    @(negedge i_clk);
    if (o_deq_rxq) begin
      if (i_rxq_empty) bad_deq++;
      if (i_rxq_data == SYNC && sync_deq_cyc < 0) sync_deq_cyc = cyc;
      pend_pop = 1;
    end
    if (o_reg_req && req_run == 1 && req_rise_cyc < 0) req_rise_cyc = cyc;
    if (o_enq_txq) begin
      if (i_txq_full) bad_enq++;
      tx_got.push_back(o_txq_data);
      if (first_enq_cyc < 0) first_enq_cyc = cyc;
    end
    if (o_frame_err) ferr_cnt++;
    cyc++;
  endtask

  task automatic build_frame(input int ngarb, input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input bit bad_chk);
    logic [7:0] g;
    logic [7:0] x;
    frm.delete();
    for (int k = 0; k < ngarb; k++) begin
      g = 8'($urandom);
      if (g == SYNC) g = 8'h00;
      frm.push_back(g);
    end
    frm.push_back(SYNC);
    frm.push_back(cmd);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      frm.push_back(addr);
      x = cmd ^ addr;
      if (cmd == 8'h01) begin
        frm.push_back(data);
        x = x ^ data;
      end
      if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
      frm.push_back(x);
`endif
    end
  endtask

  // Frame-level reference: what a correct bridge must do with the bytes in frm.
  function automatic void model(input int ack_d, input logic [7:0] rd);
    int i;
    logic [7:0] cmd;
    bit nak;
    i = 0;
    nak = 0;
    exp_tx.delete();
    exp_req = 0; exp_len = 0; exp_ferr = 0; exp_we = 0; exp_addr = 8'h00; exp_wdata = 8'h00;
    while (frm[i] != SYNC) i++;
    i++;
    cmd = frm[i];
    i++;
    if (cmd != 8'h01 && cmd != 8'h02) begin
      nak = 1;
    end else begin
      exp_we = (cmd == 8'h01);
      exp_addr = frm[i];
      i++;
      if (exp_we) begin
        exp_wdata = frm[i];
        i++;
      end
`ifdef UART_CMD_BRIDGE_CHKSUM_EN
      if (frm[i] != (cmd ^ exp_addr ^ exp_wdata)) nak = 1;
`endif
      if (!nak) begin
        exp_req = 1;
        if (ack_d < 0 || ack_d >= TMO) begin
          nak = 1;
          exp_len = TMO;
        end else begin
          exp_len = ack_d + 1;
          exp_tx.push_back(8'h06);
          if (!exp_we) exp_tx.push_back(rd);
        end
      end
    end
    if (nak) begin
      exp_tx.push_back(8'h15);
      exp_ferr = 1;
    end
  endfunction

  task automatic run_frame(input string name, input int ack_d, input logic [7:0] rd);
    bit done;
    clear_stats();
    ack_delay = ack_d;
    bus_rdata = rd;
    model(ack_d, rd);
    src_q = frm;
    done = 0;
    for (int n = 0; n < MAX_CYC && !done; n++) begin
      step();
      done = (src_q.size() == 0 && rx_q.size() == 0 && !o_busy);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s completion: frame still busy after %0d cycles", name, MAX_CYC); end
    checks++;
    if (tx_got.size() != exp_tx.size()) begin
      errors++; $display("FAIL %s tx_count: got %0d expected %0d", name, tx_got.size(), exp_tx.size());
    end
    for (int k = 0; k < exp_tx.size() && k < tx_got.size(); k++) begin
      checks++;
      if (tx_got[k] !== exp_tx[k]) begin
        errors++; $display("FAIL %s tx_byte[%0d]: got %02h expected %02h", name, k, tx_got[k], exp_tx[k]);
      end
    end
    checks++;
    if (req_cnt != int'(exp_req)) begin errors++; $display("FAIL %s req_count: got %0d expected %0d", name, req_cnt, exp_req); end
    if (exp_req && req_cnt == 1) begin
      checks++;
      if (seen_we !== exp_we || seen_addr !== exp_addr || (exp_we && seen_wdata !== exp_wdata)) begin
        errors++;
        $display("FAIL %s bus_fields: got we=%0b addr=%02h wdata=%02h expected we=%0b addr=%02h wdata=%02h",
                 name, seen_we, seen_addr, seen_wdata, exp_we, exp_addr, exp_wdata);
      end
      checks++;
      if (last_req_len != exp_len) begin errors++; $display("FAIL %s req_len: got %0d expected %0d", name, last_req_len, exp_len); end
    end
    checks++;
    if (ferr_cnt != exp_ferr) begin errors++; $display("FAIL %s frame_err: got %0d expected %0d", name, ferr_cnt, exp_ferr); end
    checks++;
    if (bad_enq != 0 || bad_deq != 0 || unstable != 0) begin
      errors++; $display("FAIL %s protocol: enq_while_full=%0d deq_while_empty=%0d unstable=%0d expected 0/0/0",
                         name, bad_enq, bad_deq, unstable);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_rxq_empty = 1'b0; i_rxq_data = SYNC; i_txq_full = 1'b0; i_reg_ack = 1'b0; i_reg_rdata = 8'h00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_deq_rxq, o_enq_txq, o_reg_req, o_busy, o_frame_err} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %05b expected 00000", {o_deq_rxq, o_enq_txq, o_reg_req, o_busy, o_frame_err});
    end
    checks++;
    if ({o_reg_we, o_reg_addr, o_reg_wdata, o_txq_data} !== 25'b0) begin
      errors++; $display("FAIL reset_data: got we=%0b addr=%02h wdata=%02h txd=%02h expected zeros",
                         o_reg_we, o_reg_addr, o_reg_wdata, o_txq_data);
    end
    i_rxq_empty = 1'b1; i_rxq_data = 8'h00;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (o_busy !== 1'b0 || o_deq_rxq !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%0b deq=%0b expected 0/0", o_busy, o_deq_rxq);
    end
  endtask

  task automatic test_write();
    gap_pct = 0; full_pct = 0;
    build_frame(0, 8'h01, 8'h3C, 8'h7E, 0);
    run_frame("write", 3, 8'h00);
    checks++;
    if (req_rise_cyc - sync_deq_cyc != LAT_W) begin
      errors++; $display("FAIL write_latency: got %0d expected %0d", req_rise_cyc - sync_deq_cyc, LAT_W);
    end
    checks++;
    if (first_enq_cyc - ack_cyc != 1) begin
      errors++; $display("FAIL ack_to_enq: got %0d expected 1", first_enq_cyc - ack_cyc);
    end
  endtask

  task automatic test_read();
    gap_pct = 0; full_pct = 0;
    build_frame(0, 8'h02, 8'h10, 8'h00, 0);
    run_frame("read", 2, 8'hC3);
  endtask

  task automatic test_bad_cmd();
    gap_pct = 0; full_pct = 0;
    frm = '{8'h00, 8'hFF, SYNC, 8'h07};
    run_frame("bad_cmd", 0, 8'h00);
  endtask

  task automatic test_timeout();
    gap_pct = 0; full_pct = 0;
    build_frame(0, 8'h02, 8'h44, 8'h00, 0);
    run_frame("timeout", -1, 8'h99);
    build_frame(0, 8'h02, 8'h45, 8'h00, 0);
    run_frame("ack_last_cycle", TMO - 1, 8'h6B);
    build_frame(0, 8'h01, 8'h46, 8'h12, 0);
    run_frame("ack_too_late", TMO, 8'h00);
  endtask

  task automatic test_backpressure();
    gap_pct = 0; full_pct = 0; bp_arm = 50;
    build_frame(0, 8'h02, 8'h20, 8'h00, 0);
    run_frame("backpressure", 1, 8'h5A);
    checks++;
    if (first_enq_cyc - ack_cyc != 51) begin
      errors++; $display("FAIL bp_release: got %0d expected 51", first_enq_cyc - ack_cyc);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    gap_pct = 0; full_pct = 0;
    clear_stats();
    ack_delay = -1;
    build_frame(1, 8'h02, 8'h31, 8'h00, 0);
    src_q = frm;
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      step();
      hit = (req_run >= 5);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_reach_bus: got req_run=%0d expected >=5", req_run); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_reg_req !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req=%0b busy=%0b expected 0/0", o_reg_req, o_busy);
    end
    src_q.delete(); rx_q.delete(); pend_pop = 0; req_run = 0;
    i_rxq_empty = 1'b1; i_rxq_data = 8'h00; i_reg_ack = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    build_frame(0, 8'h01, 8'($urandom), 8'($urandom), 0);
    run_frame("after_reset", 2, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int ackd;
    for (int it = 0; it < 40; it++) begin
      gap_pct  = $urandom_range(0, 60);
      full_pct = $urandom_range(0, 40);
      case ($urandom_range(0, 9))
        0:       cmd = 8'($urandom);
        1, 2, 3, 4: cmd = 8'h01;
        default: cmd = 8'h02;
      endcase
      ackd = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 8));
      build_frame($urandom_range(0, 2), cmd, 8'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
      run_frame("random", ackd, 8'($urandom));
    end
    gap_pct = 0; full_pct = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
